// File: rtl/board_play.sv
// board_play: lights-out play engine for a 3x4 grid.
//
// A board pattern from the generator is latched on a load pulse. Each move
// toggles the selected cell and its orthogonal neighbours and counts toward
// a move budget. A round ends in WIN when every cell is clear, or in LOSE
// when the budget is used up.
//
// Ports:
//   clk      divided game clock; all logic runs on its rising edge
//   rst_n    synchronous, active-low reset
//   board    puzzle pattern; bit i is cell i (row i/4, column i%4)
//   load     one-cycle pulse: latch board and start a round
//   enable   start switch level; moves are ignored while low
//   sel      selected cell index, 0..11
//   go_flag  one-cycle move pulse
//   cells    current board state (drives the LEDs)
//   moves    moves made this round
//   playing  high while a round is in progress
//   win      high once the board has been cleared
//   lose     high once the move budget is exhausted
module board_play #(
   parameter int MAX_MOVES = 31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] board,
   input  logic        load,
   input  logic        enable,
   input  logic [3:0]  sel,
   input  logic        go_flag,
   output logic [11:0] cells,
   output logic [7:0]  moves,
   output logic        playing,
   output logic        win,
   output logic        lose
);

   typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

   state_t      state_q, state_d;
   logic [11:0] cells_q, cells_d;
   logic [7:0]  moves_q, moves_d;
   logic        move_ok;

   // Toggle pattern for a cell: itself plus whichever neighbours exist.
   // Neighbours never wrap across a row end or a grid edge.
   function automatic logic [11:0] move_mask(input logic [3:0] s);
      logic [11:0] m;
      logic [1:0]  row;
      logic [1:0]  col;
      m   = '0;
      row = s[3:2];
      col = s[1:0];
      if (s <= 4'd11) begin
         m[s] = 1'b1;
         if (row != 2'd0) m[4'(s - 4'd4)] = 1'b1;
         if (row <  2'd2) m[4'(s + 4'd4)] = 1'b1;
         if (col != 2'd0) m[4'(s - 4'd1)] = 1'b1;
         if (col != 2'd3) m[4'(s + 4'd1)] = 1'b1;
      end
      return m;
   endfunction

   // Move counter increment that sticks at the top of its range.
   function automatic logic [7:0] sat_inc(input logic [7:0] m);
      return (m == 8'hFF) ? m : m + 8'd1;
   endfunction

   assign move_ok = (state_q == PLAY) && go_flag && enable &&
                    (sel <= 4'd11) && !load;

   always_comb begin
      state_d = state_q;
      cells_d = cells_q;
      moves_d = moves_q;
      if (load) begin
         // A load overrides any move presented on the same edge.
         cells_d = board;
         moves_d = 8'd0;
         state_d = (board != 12'd0) ? PLAY : WIN;
      end else if (move_ok) begin
         cells_d = cells_q ^ move_mask(sel);
         moves_d = sat_inc(moves_q);
         // End-of-round is judged on the post-move values so the result
         // appears on the same edge as the move; clearing beats budget.
         if (cells_d == 12'd0)
            state_d = WIN;
         else if (moves_d == 8'(MAX_MOVES))
            state_d = LOSE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cells_q <= '0;
         moves_q <= '0;
      end else begin
         state_q <= state_d;
         cells_q <= cells_d;
         moves_q <= moves_d;
      end
   end

   assign cells   = cells_q;
   assign moves   = moves_q;
   assign playing = (state_q == PLAY);
   assign win     = (state_q == WIN);
   assign lose    = (state_q == LOSE);

endmodule

// File: tb/tb_board_play.sv
// Directed bench for board_play. Stimulus pushes hand-computed expectations
// into a queue one cycle at a time; an independent monitor pops and checks
// them on the falling edge. Two instances share all inputs: one with the
// default budget and one with a budget of 3 for the lose/priority cases.
module tb_board_play;

   logic        clk;
   logic        rst_n;
   logic [11:0] board;
   logic        load;
   logic        enable;
   logic [3:0]  sel;
   logic        go_flag;

   logic [11:0] cells_a, cells_b;
   logic [7:0]  moves_a, moves_b;
   logic        playing_a, playing_b, win_a, win_b, lose_a, lose_b;

   typedef struct {
      int          dut;
      string       name;
      logic [11:0] cells;
      logic [7:0]  moves;
      logic        playing;
      logic        win;
      logic        lose;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 0;

   board_play dut_a (
      .clk(clk), .rst_n(rst_n), .board(board), .load(load), .enable(enable),
      .sel(sel), .go_flag(go_flag), .cells(cells_a), .moves(moves_a),
      .playing(playing_a), .win(win_a), .lose(lose_a)
   );

   board_play #(.MAX_MOVES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .board(board), .load(load), .enable(enable),
      .sel(sel), .go_flag(go_flag), .cells(cells_b), .moves(moves_b),
      .playing(playing_b), .win(win_b), .lose(lose_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare every pending expectation against the selected DUT.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         logic [22:0] act, req;
         e = q.pop_front();
         if (e.dut == 0) act = {cells_a, moves_a, playing_a, win_a, lose_a};
         else            act = {cells_b, moves_b, playing_b, win_b, lose_b};
         req = {e.cells, e.moves, e.playing, e.win, e.lose};
         checks++;
         if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d: got cells=%h moves=%0d p/w/l=%b, want cells=%h moves=%0d p/w/l=%b",
                     e.name, e.dut, act[22:11], act[10:3], act[2:0],
                     req[22:11], req[10:3], req[2:0]);
         end
      end
   end

   task automatic expect_st(input int d, input string n, input logic [11:0] c,
                            input logic [7:0] m, input logic p, input logic w,
                            input logic l);
      exp_t e;
      e.dut = d; e.name = n; e.cells = c; e.moves = m;
      e.playing = p; e.win = w; e.lose = l;
      q.push_back(e);
   endtask

   // One edge with the given controls; pulses drop again right after it.
   task automatic step(input logic r, input logic ld, input logic [11:0] b,
                       input logic g, input logic en, input logic [3:0] s);
      rst_n   = r;
      load    = ld;
      board   = b;
      go_flag = g;
      enable  = en;
      sel     = s;
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      load    = 1'b0;
      go_flag = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; board = '0; load = 0; enable = 1; sel = '0; go_flag = 0;
      @(negedge clk);

      // Reset state
      step(0, 0, 12'h000, 0, 1, 4'd0);
      expect_st(0, "reset_a", 12'h000, 8'd0, 0, 0, 0);
      expect_st(1, "reset_b", 12'h000, 8'd0, 0, 0, 0);

      // One-move win from the centre-left cell
      step(1, 1, 12'h272, 0, 1, 4'd0);
      expect_st(0, "load_272", 12'h272, 8'd0, 1, 0, 0);
      step(1, 0, 12'h000, 1, 1, 4'd5);
      expect_st(0, "move5_win", 12'h000, 8'd1, 0, 1, 0);

      // Corner moves
      step(1, 1, 12'h001, 0, 1, 4'd0);
      expect_st(0, "load_001", 12'h001, 8'd0, 1, 0, 0);
      step(1, 0, 12'h000, 1, 1, 4'd11);
      expect_st(0, "move11", 12'hC81, 8'd1, 1, 0, 0);
      step(1, 0, 12'h000, 1, 1, 4'd0);
      expect_st(0, "move0", 12'hC92, 8'd2, 1, 0, 0);

      // Ignored moves: out-of-range cell, paused
      step(1, 0, 12'h000, 1, 1, 4'd12);
      expect_st(0, "sel12_ign", 12'hC92, 8'd2, 1, 0, 0);
      step(1, 0, 12'h000, 1, 1, 4'd15);
      expect_st(0, "sel15_ign", 12'hC92, 8'd2, 1, 0, 0);
      step(1, 0, 12'h000, 1, 0, 4'd5);
      expect_st(0, "paused_ign", 12'hC92, 8'd2, 1, 0, 0);

      // Load and move together: load wins
      step(1, 1, 12'h0F0, 1, 1, 4'd5);
      expect_st(0, "load_go", 12'h0F0, 8'd0, 1, 0, 0);

      // Two back-to-back moves (top-right edge, interior), then reset
      step(1, 0, 12'h000, 1, 1, 4'd3);
      expect_st(0, "move3", 12'h07C, 8'd1, 1, 0, 0);
      step(1, 0, 12'h000, 1, 1, 4'd6);
      expect_st(0, "move6", 12'h498, 8'd2, 1, 0, 0);
      step(0, 0, 12'h000, 0, 1, 4'd0);
      expect_st(0, "midround_rst", 12'h000, 8'd0, 0, 0, 0);

      // Empty board wins immediately
      step(1, 1, 12'h000, 0, 1, 4'd0);
      expect_st(0, "load_empty_win", 12'h000, 8'd0, 0, 1, 0);
      expect_st(1, "load_empty_b", 12'h000, 8'd0, 0, 1, 0);

      // Budget of 3 on dut_b: lose on the third move, then frozen
      step(1, 1, 12'h001, 0, 1, 4'd0);
      expect_st(1, "b_load_001", 12'h001, 8'd0, 1, 0, 0);
      step(1, 0, 12'h000, 1, 1, 4'd11);
      expect_st(1, "b_move1", 12'hC81, 8'd1, 1, 0, 0);
      step(1, 0, 12'h000, 1, 1, 4'd11);
      expect_st(1, "b_move2", 12'h001, 8'd2, 1, 0, 0);
      step(1, 0, 12'h000, 1, 1, 4'd11);
      expect_st(1, "b_move3_lose", 12'hC81, 8'd3, 0, 0, 1);
      step(1, 0, 12'h000, 1, 1, 4'd11);
      expect_st(1, "b_lose_hold", 12'hC81, 8'd3, 0, 0, 1);

      // Clearing on the last budgeted move is a win, not a loss
      step(1, 1, 12'h013, 0, 1, 4'd0);
      expect_st(1, "b_load_013", 12'h013, 8'd0, 1, 0, 0);
      step(1, 0, 12'h000, 1, 1, 4'd11);
      expect_st(1, "b_p1", 12'hC93, 8'd1, 1, 0, 0);
      step(1, 0, 12'h000, 1, 1, 4'd11);
      expect_st(1, "b_p2", 12'h013, 8'd2, 1, 0, 0);
      step(1, 0, 12'h000, 1, 1, 4'd0);
      expect_st(1, "b_win_priority", 12'h000, 8'd3, 0, 1, 0);
      step(1, 0, 12'h000, 1, 1, 4'd5);
      expect_st(1, "b_win_hold", 12'h000, 8'd3, 0, 1, 0);

      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: pending=%0d required=0", q.size());
      end
      done = 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      if (!done) begin
         $display("FAIL timeout: bench did not complete");
         $fatal(1, "timeout");
      end
   end

endmodule
